aes_round_engine: RTL and testbench

//  Parametrised iterative AES engine: one round per clock, encrypt or decrypt selected per block.

---
 rtl/aes_round_engine.sv | 198 +++++++++++++++++++
 tb/tb_aes_round_engine.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_engine.sv
// Iterative AES-128/192/256 engine: one cipher or inverse-cipher round per clock with
// valid/ready on both sides; round keys come pre-expanded on a flat bus.
module aes_round_engine #(
    parameter int NK = 4,
    parameter int NR = NK + 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_decrypt,
    input  logic [127:0]            in_data,
    input  logic [128*(NR+1)-1:0]   ExpandedKeys,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [127:0]            out_data,
    output logic                    out_decrypt,
    output logic                    busy
);

    if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
        $error("aes_round_engine: NK must be 4, 6 or 8");
    end
    if (NR != NK + 6) begin : g_bad_nr
        $error("aes_round_engine: NR must equal NK+6");
    end

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    // Entry n of each table sits at bits [2047-8n -: 8].
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    localparam logic [2047:0] INV_SBOX_TABLE = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] c);
        logic [7:0] p;
        logic [7:0] a;
        p = 8'h00;
        a = b;
        for (int i = 0; i < 4; i++) begin
            if (c[i]) p = p ^ a;
            a = xtime(a);
        end
        return p;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
        return o;
    endfunction

    // Byte (row r, column c) lives at index 4c+r, counted from the MSB end.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
        return o;
    endfunction

    // Circulant column mix; {2,3,1,1} forward, {e,b,d,9} inverse.
    function automatic logic [127:0] mix_columns(input logic [127:0] s,
                                                 input logic [3:0] k0, input logic [3:0] k1,
                                                 input logic [3:0] k2, input logic [3:0] k3);
        logic [127:0] o;
        logic [7:0]   a [4];
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = s[127-8*(4*c+r) -: 8];
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = gmul(a[r], k0) ^ gmul(a[(r+1)%4], k1) ^
                                        gmul(a[(r+2)%4], k2) ^ gmul(a[(r+3)%4], k3);
        end
        return o;
    endfunction

    state_t         state_q, state_d;
    logic [3:0]     rnd_q, rnd_d;
    logic [127:0]   st_q, st_d;
    logic           dec_q, dec_d;

    logic [127:0]   rk [NR+1];
    logic [3:0]     key_idx;
    logic [127:0]   rk_cur;
    logic           last_round;
    logic           accept;
    logic [127:0]   enc_sr, enc_mc, dec_ark, round_out;

    for (genvar r = 0; r <= NR; r++) begin : g_rk
        assign rk[r] = ExpandedKeys[128*(NR+1-r)-1 -: 128];
    end

    assign accept = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rnd_q   <= 4'd0;
            st_q    <= 128'd0;
            dec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            st_q    <= st_d;
            dec_q   <= dec_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ROUND;
            ROUND:   if (last_round) state_d = DONE;
            DONE:    if (out_ready) state_d = accept ? ROUND : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Decrypt walks the key schedule backwards, so the key index mirrors the round count.
    always_comb begin
        last_round = (rnd_q == 4'(NR));
        key_idx    = dec_q ? 4'(NR) - rnd_q : rnd_q;
        rk_cur     = rk[key_idx];
        enc_sr     = shift_rows(sub_bytes(st_q));
        enc_mc     = mix_columns(enc_sr, 4'h2, 4'h3, 4'h1, 4'h1);
        dec_ark    = inv_sub_bytes(inv_shift_rows(st_q)) ^ rk_cur;
        if (dec_q)
            round_out = last_round ? dec_ark : mix_columns(dec_ark, 4'he, 4'hb, 4'hd, 4'h9);
        else
            round_out = (last_round ? enc_sr : enc_mc) ^ rk_cur;
    end

    always_comb begin
        st_d  = st_q;
        rnd_d = rnd_q;
        dec_d = dec_q;
        if (accept) begin
            dec_d = in_decrypt;
            st_d  = in_data ^ (in_decrypt ? rk[NR] : rk[0]);
            rnd_d = 4'd1;
        end else if (state_q == ROUND) begin
            st_d = round_out;
            if (!last_round) rnd_d = rnd_q + 4'd1;
        end
    end

    always_comb begin
        in_ready    = !reset && (state_q == IDLE || (state_q == DONE && out_ready));
        out_valid   = (state_q == DONE);
        busy        = (state_q == ROUND);
        out_data    = st_q;
        out_decrypt = dec_q;
    end

endmodule

// File: tb/tb_aes_round_engine.sv
// Directed bench for aes_round_engine: FIPS-197 vectors on NK=4/6/8 instances,
// handshake latency, backpressure, back-to-back blocks and mid-operation reset.
module tb_aes_round_engine;

    localparam logic [127:0] PT1    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT5    = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT5    = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY5   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid [3];
    logic           in_ready [3];
    logic           in_decrypt;
    logic [127:0]   in_data;
    logic           out_valid [3];
    logic           out_ready [3];
    logic [127:0]   out_data [3];
    logic           out_decrypt [3];
    logic           busy [3];
    logic [1407:0]  keys4;
    logic [1663:0]  keys6;
    logic [1919:0]  keys8;
    logic [1919:0]  flat;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes_round_engine #(.NK(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_decrypt(in_decrypt), .in_data(in_data), .ExpandedKeys(keys4),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .out_decrypt(out_decrypt[0]), .busy(busy[0])
    );
    aes_round_engine #(.NK(6)) dut6 (
        .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_decrypt(in_decrypt), .in_data(in_data), .ExpandedKeys(keys6),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .out_decrypt(out_decrypt[1]), .busy(busy[1])
    );
    aes_round_engine #(.NK(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_decrypt(in_decrypt), .in_data(in_data), .ExpandedKeys(keys8),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
        .out_decrypt(out_decrypt[2]), .busy(busy[2])
    );

    function automatic logic [7:0] tb_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = tb_xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box derived from its definition: GF(2^8) inverse (x^254) followed by the affine map.
    function automatic logic [7:0] ref_sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        if (x != 8'h00) begin
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = gf_mul(inv, x);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {ref_sbox(w[31:24]), ref_sbox(w[23:16]), ref_sbox(w[15:8]), ref_sbox(w[7:0])};
    endfunction

    // Key schedule packed with word 0 at the MSB end, matching the round-key bus layout.
    function automatic logic [1919:0] expand_key(input logic [255:0] key, input int nk);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rcon;
        logic [1919:0] f;
        int            nw;
        nw   = 4 * (nk + 7);
        rcon = 8'h01;
        f    = '0;
        for (int i = 0; i < 60; i++) w[i] = 32'h0;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < nw; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = tb_xtime(rcon);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int i = 0; i < nw; i++) f[1919-32*i -: 32] = w[i];
        return f;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic applyStimulus(input int d, input logic dec, input logic [127:0] din);
        in_data    = din;
        in_decrypt = dec;
        in_valid[d] = 1'b1;
        #1;
        checkOutput("in_ready_before_accept", 128'(in_ready[d]), 128'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid[d] = 1'b0;
        in_decrypt  = ~dec;
        in_data     = 128'hdeadbeef_cafef00d_01234567_89abcdef;
        checkOutput("busy_after_accept", 128'(busy[d]), 128'd1);
    endtask

    task automatic waitResult(input int d, input int nr, input logic [127:0] exp_data,
                              input logic exp_dec, input string tag);
        int edges;
        edges = 0;
        while (out_valid[d] !== 1'b1 && edges < 64) begin
            @(negedge clk);
            edges++;
        end
        checkOutput({tag, "_latency"}, 128'(edges), 128'(nr));
        checkOutput({tag, "_data"}, out_data[d], exp_data);
        checkOutput({tag, "_decrypt"}, 128'(out_decrypt[d]), 128'(exp_dec));
    endtask

    initial begin
        logic stale;
        reset      = 1'b1;
        in_decrypt = 1'b0;
        in_data    = 128'h0;
        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b1;
        end
        flat  = expand_key(KEY128, 4);
        keys4 = flat[1919 -: 1408];
        flat  = expand_key(KEY192, 6);
        keys6 = flat[1919 -: 1664];
        keys8 = expand_key(KEY256, 8);

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_out_valid", 128'(out_valid[0]), 128'd0);
        checkOutput("reset_out_data", out_data[0], 128'd0);
        checkOutput("reset_out_decrypt", 128'(out_decrypt[0]), 128'd0);
        checkOutput("reset_busy", 128'(busy[0]), 128'd0);
        checkOutput("reset_in_ready", 128'(in_ready[0]), 128'd0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] T1 AES-128 encrypt");
        applyStimulus(0, 1'b0, PT1);
        waitResult(0, 10, CT128, 1'b0, "t1");
        @(negedge clk);
        checkOutput("t1_out_valid_drop", 128'(out_valid[0]), 128'd0);

        $display("[TB] T2 AES-128 decrypt");
        applyStimulus(0, 1'b1, CT128);
        waitResult(0, 10, PT1, 1'b1, "t2");
        @(negedge clk);

        $display("[TB] T3 AES-192 / AES-256 encrypt");
        applyStimulus(1, 1'b0, PT1);
        waitResult(1, 12, CT192, 1'b0, "t3_192");
        @(negedge clk);
        applyStimulus(2, 1'b0, PT1);
        waitResult(2, 14, CT256, 1'b0, "t3_256");
        @(negedge clk);

        $display("[TB] T4 output backpressure");
        out_ready[0] = 1'b0;
        applyStimulus(0, 1'b0, PT1);
        waitResult(0, 10, CT128, 1'b0, "t4a");
        in_valid[0] = 1'b1;
        in_decrypt  = 1'b1;
        in_data     = CT128;
        repeat (5) begin
            @(negedge clk);
            checkOutput("t4_stall_valid", 128'(out_valid[0]), 128'd1);
            checkOutput("t4_stall_data", out_data[0], CT128);
            checkOutput("t4_stall_in_ready", 128'(in_ready[0]), 128'd0);
        end
        out_ready[0] = 1'b1;
        #1;
        checkOutput("t4_release_in_ready", 128'(in_ready[0]), 128'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        checkOutput("t4_release_out_valid", 128'(out_valid[0]), 128'd0);
        checkOutput("t4_release_busy", 128'(busy[0]), 128'd1);
        waitResult(0, 10, PT1, 1'b1, "t4b");
        @(negedge clk);

        $display("[TB] T5 back-to-back encrypt/decrypt");
        flat  = expand_key(KEY5, 4);
        keys4 = flat[1919 -: 1408];
        @(negedge clk);
        applyStimulus(0, 1'b0, PT5);
        waitResult(0, 10, CT5, 1'b0, "t5_enc");
        applyStimulus(0, 1'b1, CT5);
        waitResult(0, 10, PT5, 1'b1, "t5_dec");
        applyStimulus(0, 1'b0, PT5);
        waitResult(0, 10, CT5, 1'b0, "t5_enc2");
        @(negedge clk);

        $display("[TB] T6 reset mid-operation");
        flat  = expand_key(KEY128, 4);
        keys4 = flat[1919 -: 1408];
        @(negedge clk);
        applyStimulus(0, 1'b0, PT1);
        repeat (4) @(negedge clk);
        checkOutput("t6_busy_round5", 128'(busy[0]), 128'd1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("t6_out_valid", 128'(out_valid[0]), 128'd0);
        checkOutput("t6_busy", 128'(busy[0]), 128'd0);
        checkOutput("t6_in_ready", 128'(in_ready[0]), 128'd0);
        checkOutput("t6_out_data", out_data[0], 128'd0);
        reset = 1'b0;
        #1;
        checkOutput("t6_idle_in_ready", 128'(in_ready[0]), 128'd1);
        stale = 1'b0;
        repeat (20) begin
            @(negedge clk);
            stale = stale | out_valid[0];
        end
        checkOutput("t6_no_stale_output", 128'(stale), 128'd0);
        applyStimulus(0, 1'b0, PT1);
        waitResult(0, 10, CT128, 1'b0, "t6_fresh");
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
